// File: rtl/gf8_pkg.sv
// Shared constants and state encoding for the GF(2^3) exponentiation controller.
// Field polynomial is P(x) = x^3 + x^2 + 1; Montgomery radix is R = x^3.
package gf8_pkg;

  localparam logic [3:0] P_X      = 4'b1101;
  localparam logic [2:0] MONT_ONE = 3'b101;  // x^3 mod P
  localparam logic [2:0] MONT_R2  = 3'b110;  // x^6 mod P
  localparam logic [2:0] GF_ONE   = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CONV  = 3'd1,
    S_SQR   = 3'd2,
    S_MUL   = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/gf8_exp_ctrl_mr_block.sv
// Combinational GF(2^3) Montgomery multiplier: G = A*B*x^-3 mod P(x).
// Each reduction step cancels the x^0 term with P and divides by x.
module MR_block
  import gf8_pkg::*;
(
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic [2:0] G
);

  logic [4:0] t;

  always_comb begin
    t = 5'b00000;
    for (int k = 0; k < 3; k++) begin
      if (B[k]) t = t ^ ({2'b00, A} << k);
    end
    for (int k = 0; k < 3; k++) begin
      if (t[0]) t = t ^ {1'b0, P_X};
      t = t >> 1;
    end
    G = t[2:0];
  end

endmodule

// File: rtl/gf8_exp_ctrl.sv
// Left-to-right square-and-multiply a^e over GF(2^3) using one shared
// Montgomery multiplier; operands live in the Montgomery domain until FINAL.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; latches base/exp, acc = MONT_ONE, i = 3
// S_CONV  | bm = M(bm, MONT_R2), base into Montgomery domain
// S_SQR   | acc = M(acc, acc) for exponent bit i
// S_MUL   | acc = M(acc, bm) when exponent bit i is set
// S_FINAL | result = M(acc, 1), back to polynomial basis
// S_DONE  | done pulse for one cycle
module gf8_exp_ctrl
  import gf8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] base,
  input  logic [3:0] exp,
  output logic       busy,
  output logic       done,
  output logic [2:0] result
);

  state_t     state, state_nxt;
  logic [2:0] bm, acc;
  logic [3:0] e_reg;
  logic [1:0] i;
  logic [2:0] op_a, op_b, mr_g;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CONV;
      S_CONV:  state_nxt = S_SQR;
      S_SQR: begin
        if (e_reg[i])      state_nxt = S_MUL;
        else if (i == 2'd0) state_nxt = S_FINAL;
      end
      S_MUL:   state_nxt = (i == 2'd0) ? S_FINAL : S_SQR;
      S_FINAL: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Operand mux for the single shared multiplier.
  always_comb begin
    op_a = acc;
    op_b = acc;
    case (state)
      S_CONV:  begin op_a = bm;  op_b = MONT_R2; end
      S_MUL:   begin op_a = acc; op_b = bm;      end
      S_FINAL: begin op_a = acc; op_b = GF_ONE;  end
      default: begin op_a = acc; op_b = acc;     end
    endcase
  end

  MR_block u_mr (
    .A (op_a),
    .B (op_b),
    .G (mr_g)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bm     <= 3'b000;
      acc    <= 3'b000;
      e_reg  <= 4'b0000;
      i      <= 2'd0;
      result <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bm    <= base;
            e_reg <= exp;
            acc   <= MONT_ONE;
            i     <= 2'd3;
          end
        end
        S_CONV: bm <= mr_g;
        S_SQR: begin
          acc <= mr_g;
          if (!e_reg[i] && (i != 2'd0)) i <= i - 2'd1;
        end
        S_MUL: begin
          acc <= mr_g;
          if (i != 2'd0) i <= i - 2'd1;
        end
        S_FINAL: result <= mr_g;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf8_exp_ctrl.sv
// Scoreboard bench for gf8_exp_ctrl: the driver queues expected result and
// done cycle per start; an independent monitor checks every done pulse.
module tb_gf8_exp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] base;
  logic [3:0] exp;
  logic       busy;
  logic       done;
  logic [2:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0] res;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];

  gf8_exp_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base),
    .exp    (exp),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
    logic [5:0] p;
    p = 6'd0;
    for (int k = 0; k < 3; k++) if (b[k]) p = p ^ ({3'b000, a} << k);
    for (int k = 4; k >= 3; k--) if (p[k]) p = p ^ ({2'b00, 4'b1101} << (k - 3));
    return p[2:0];
  endfunction

  function automatic logic [2:0] gf_pow(input logic [2:0] a, input logic [3:0] e);
    logic [2:0] r;
    r = 3'b001;
    for (int k = 0; k < int'(e); k++) r = gf_mul(r, a);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Called at #1 after an edge in an IDLE cycle; returns in the cycle after done.
  task automatic run_op(input logic [2:0] b, input logic [3:0] e, input logic [2:0] r,
                        input bit repulse, input string nm);
    bit   got;
    exp_t x;
    x.res  = r;
    x.cyc  = cyc + 7 + $countones(e);
    x.name = nm;
    sb.push_back(x);
    base  = b;
    exp   = e;
    start = 1'b1;
    step();
    start = 1'b0;
    base  = ~b;
    exp   = ~e;
    got   = 1'b0;
    for (int k = 1; k < 40; k++) begin
      if (done) begin
        got = 1'b1;
        if (repulse) begin
          start = 1'b1;
          base  = 3'b111;
          exp   = 4'hf;
        end
        break;
      end
      start = repulse && (k % 3 == 0);
      base  = 3'($urandom);
      exp   = 4'($urandom);
      step();
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: no done within 40 cycles", nm);
    end
    step();
    start = 1'b0;
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: cycle %0d result %b, none expected", cyc, result);
        end else begin
          e = sb.pop_front();
          n_chk++;
          if (result !== e.res) begin
            n_fail++;
            $display("FAIL %s result: got %b expected %b", e.name, result, e.res);
          end
          n_chk++;
          if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d expected %0d", e.name, cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base  = 3'b000;
    exp   = 4'h0;
    #1;
    step();
    step();
    check("reset_busy",   {7'd0, busy},   8'd0);
    check("reset_done",   {7'd0, done},   8'd0);
    check("reset_result", {5'd0, result}, 8'd0);
    rst_n = 1'b1;

    run_op(3'b010, 4'd3,  3'b101, 1'b0, "x_pow3");
    run_op(3'b010, 4'd4,  3'b111, 1'b0, "x_pow4");
    run_op(3'b010, 4'd7,  3'b001, 1'b0, "x_pow7");
    run_op(3'b000, 4'd0,  3'b001, 1'b0, "zero_pow0");
    run_op(3'b000, 4'd5,  3'b000, 1'b0, "zero_pow5");
    run_op(3'b011, 4'd15, 3'b011, 1'b1, "repulse_pow15");
    check("repulse_model", {5'd0, gf_pow(3'b011, 4'd15)}, {5'd0, result});

    // Reset in cycle 4 of an exp=15 run: aborted with no done.
    base  = 3'b011;
    exp   = 4'd15;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy",   {7'd0, busy},   8'd0);
    check("abort_done",   {7'd0, done},   8'd0);
    check("abort_result", {5'd0, result}, 8'd0);
    run_op(3'b101, 4'd2, 3'b110, 1'b0, "after_reset");

    for (int b = 0; b < 8; b++) begin
      for (int e = 0; e < 16; e++) begin
        run_op(3'(b), 4'(e), gf_pow(3'(b), 4'(e)), 1'b0, $sformatf("sweep_b%0d_e%0d", b, e));
      end
    end

    repeat (20) step();
    check("scoreboard_empty", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
